// File: rtl/enigma_pkg.sv
// Shared definitions for the letter scrambler: letter type, rotor and
// reflector wiring tables, FSM state encoding, hop indices and the
// mod-26 reduction used by every hop.
package enigma_pkg;

  localparam int LETTERS  = 26;
  localparam int NUM_HOPS = 7;

  typedef logic [4:0]        letter_t;
  typedef logic [25:0][4:0]  wiring_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STEP   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_HOP    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Hop order: right, middle, left forward, reflector, left, middle, right back.
  localparam logic [2:0] HOP_R3_FWD  = 3'd0;
  localparam logic [2:0] HOP_R2_FWD  = 3'd1;
  localparam logic [2:0] HOP_R1_FWD  = 3'd2;
  localparam logic [2:0] HOP_REFLECT = 3'd3;
  localparam logic [2:0] HOP_R1_BWD  = 3'd4;
  localparam logic [2:0] HOP_R2_BWD  = 3'd5;
  localparam logic [2:0] HOP_R3_BWD  = 3'd6;

  // Turn a 26-character A..Z wiring string into a table of letter indices.
  function automatic wiring_t decode(input logic [8*26-1:0] s);
    wiring_t    w;
    logic [7:0] c;
    w = '0;
    for (int i = 0; i < 26; i++) begin
      c    = s[8*(25-i) +: 8] - 8'd65;
      w[i] = c[4:0];
    end
    return w;
  endfunction

  // Inverse permutation, used for the backward pass through a rotor.
  function automatic wiring_t invert(input wiring_t f);
    wiring_t v;
    v = '0;
    for (int i = 0; i < 26; i++) v[f[i]] = 5'(i);
    return v;
  endfunction

  // Reduce 0..63 into 0..25 with at most two conditional subtracts.
  function automatic letter_t mod26(input logic [5:0] v);
    logic [5:0] t;
    t = v;
    if (t >= 6'(LETTERS)) t = t - 6'(LETTERS);
    if (t >= 6'(LETTERS)) t = t - 6'(LETTERS);
    return t[4:0];
  endfunction

  localparam wiring_t ROTOR_FWD [8] = '{
    decode("EKMFLGDQVZNTOWYHXUSPAIBRCJ"),
    decode("AJDKSIRUXBLHWTMCQGZNPYFVOE"),
    decode("BDFHJLCPRTXVZNYEIWGAKMUSQO"),
    decode("ESOVPZJAYQUIRHXLNFTGKDCMWB"),
    decode("VZBRGITYUPSDNHLXAWMJQOFECK"),
    decode("JPGVOUMFYQBENHZRDKASXLICTW"),
    decode("NZJHGRCXMYSWBOUFAIVLPEKQDT"),
    decode("FKQHTLXOCBJSPDZRAMEWNIUYGV")
  };

  localparam wiring_t ROTOR_INV [8] = '{
    invert(ROTOR_FWD[0]), invert(ROTOR_FWD[1]),
    invert(ROTOR_FWD[2]), invert(ROTOR_FWD[3]),
    invert(ROTOR_FWD[4]), invert(ROTOR_FWD[5]),
    invert(ROTOR_FWD[6]), invert(ROTOR_FWD[7])
  };

  localparam wiring_t UKW_B = decode("YRUHQSLDPXNGOKMIEBFZCWVJAT");
  localparam wiring_t UKW_C = decode("FVPJIAOYEDRZXWGCTKUQSBNMHL");

endpackage

// File: rtl/letter_scrambler_if.sv
// Key-in / cipher-out handshake bundle of the letter scrambler.
// Both channels use strict valid/ready: a transfer happens on a clock edge
// where valid and ready are both 1; once valid is raised the payload is held
// stable until that edge, and valid never depends combinationally on ready.
interface letter_scrambler_if;
  import enigma_pkg::*;

  logic    in_valid;
  letter_t in_letter;
  logic    in_ready;
  logic    out_valid;
  letter_t out_letter;
  logic    out_ready;

  modport master (
    output in_valid, in_letter, out_ready,
    input  in_ready, out_valid, out_letter
  );

  modport slave (
    input  in_valid, in_letter, out_ready,
    output in_ready, out_valid, out_letter
  );

endinterface

// File: rtl/rotor_map.sv
// One routing hop: a rotor forward or backward pass with position/ring
// offset, or the reflector. Purely combinational, shared across all hops.
module rotor_map
  import enigma_pkg::*;
(
  input  letter_t    letter,
  input  letter_t    position,
  input  letter_t    ring,
  input  logic [2:0] rotor_type,
  input  logic       backward,
  input  logic       reflect,
  input  logic       reflector_sel,
  output letter_t    mapped
);

  letter_t pos_m;
  letter_t ring_m;
  letter_t offset;
  letter_t unoffset;
  letter_t s;
  letter_t w;
  wiring_t table_sel;

  // Offset into the wiring, look up, then undo the offset; reflector bypasses.
  always_comb begin
    pos_m     = mod26({1'b0, position});
    ring_m    = mod26({1'b0, ring});
    offset    = mod26({1'b0, pos_m} + 6'd26 - {1'b0, ring_m});
    unoffset  = mod26({1'b0, ring_m} + 6'd26 - {1'b0, pos_m});
    s         = mod26({1'b0, letter} + {1'b0, offset});
    table_sel = backward ? ROTOR_INV[rotor_type] : ROTOR_FWD[rotor_type];
    w         = table_sel[s];
    mapped    = mod26({1'b0, w} + {1'b0, unoffset});
    if (reflect) mapped = reflector_sel ? UKW_C[letter] : UKW_B[letter];
  end

endmodule

// File: rtl/letter_scrambler.sv
// Enigma scrambler core: per key letter, request a rotor step, wait for the
// stepping cascade to settle, route the letter through seven hops and offer
// the ciphertext on the output handshake.
module letter_scrambler
  import enigma_pkg::*;
#(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                clock,
  input  logic                reset,
  letter_scrambler_if.slave   bus,
  output logic                rotate,
  input  letter_t             rotor1,
  input  letter_t             rotor2,
  input  letter_t             rotor3,
  input  logic [2:0]          rotor_type_1,
  input  logic [2:0]          rotor_type_2,
  input  logic [2:0]          rotor_type_3,
  input  letter_t             ring_1,
  input  letter_t             ring_2,
  input  letter_t             ring_3,
  input  logic                reflector_sel,
  output logic                bad_letter,
  output state_t              state
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LAST_HOP    = 3'(NUM_HOPS - 1);

  state_t     state_q;
  state_t     state_d;
  letter_t    letter_q;
  letter_t    out_q;
  logic [2:0] hop_q;
  logic [7:0] settle_q;
  logic       bad_q;
  logic       accept;

  letter_t    hop_pos;
  letter_t    hop_ring;
  logic [2:0] hop_type;
  logic       hop_back;
  logic       hop_reflect;
  letter_t    mapped;

  assign accept = (state_q == ST_IDLE) && bus.in_valid && (bus.in_letter <= 5'd25);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept)                  state_d = ST_STEP;
      ST_STEP:                                state_d = ST_SETTLE;
      ST_SETTLE: if (settle_q == SETTLE_LAST) state_d = ST_HOP;
      ST_HOP:    if (hop_q == LAST_HOP)       state_d = ST_DONE;
      ST_DONE:   if (bus.out_ready)           state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    bus.in_ready   = (state_q == ST_IDLE);
    rotate         = (state_q == ST_STEP);
    bus.out_valid  = (state_q == ST_DONE);
    bus.out_letter = out_q;
    bad_letter     = bad_q;
    state          = state_q;
  end

  // Datapath: latch key, count settle cycles, register each hop result.
  always_ff @(posedge clock) begin
    if (!reset) begin
      letter_q <= '0;
      out_q    <= '0;
      hop_q    <= '0;
      settle_q <= '0;
      bad_q    <= 1'b0;
    end else begin
      bad_q <= (state_q == ST_IDLE) && bus.in_valid && (bus.in_letter > 5'd25);
      case (state_q)
        ST_IDLE:   if (accept) letter_q <= bus.in_letter;
        ST_STEP:   settle_q <= '0;
        ST_SETTLE: begin
          settle_q <= settle_q + 8'd1;
          hop_q    <= '0;
        end
        ST_HOP: begin
          letter_q <= mapped;
          hop_q    <= hop_q + 3'd1;
          if (hop_q == LAST_HOP) out_q <= mapped;
        end
        default: ;
      endcase
    end
  end

  // Select which rotor (or the reflector) the current hop passes through.
  always_comb begin
    hop_pos     = rotor3;
    hop_ring    = ring_3;
    hop_type    = rotor_type_3;
    hop_back    = 1'b0;
    hop_reflect = 1'b0;
    case (hop_q)
      HOP_R3_FWD: ;
      HOP_R2_FWD: begin
        hop_pos  = rotor2;
        hop_ring = ring_2;
        hop_type = rotor_type_2;
      end
      HOP_R1_FWD: begin
        hop_pos  = rotor1;
        hop_ring = ring_1;
        hop_type = rotor_type_1;
      end
      HOP_REFLECT: hop_reflect = 1'b1;
      HOP_R1_BWD: begin
        hop_pos  = rotor1;
        hop_ring = ring_1;
        hop_type = rotor_type_1;
        hop_back = 1'b1;
      end
      HOP_R2_BWD: begin
        hop_pos  = rotor2;
        hop_ring = ring_2;
        hop_type = rotor_type_2;
        hop_back = 1'b1;
      end
      HOP_R3_BWD: hop_back = 1'b1;
      default: ;
    endcase
  end

  rotor_map u_rotor_map (
    .letter        (letter_q),
    .position      (hop_pos),
    .ring          (hop_ring),
    .rotor_type    (hop_type),
    .backward      (hop_back),
    .reflect       (hop_reflect),
    .reflector_sel (reflector_sel),
    .mapped        (mapped)
  );

endmodule

// File: tb/tb_letter_scrambler.sv
// Bench for letter_scrambler: a rotor stepping stage drives the positions,
// and a letter-level Enigma model predicts every ciphertext.
module tb_letter_scrambler;
  import enigma_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT ----------------
  letter_scrambler_if bus();
  logic       rotate;
  logic       bad_letter;
  state_t     state;
  logic [4:0] pos1 = 5'd0, pos2 = 5'd0, pos3 = 5'd0;
  logic [2:0] typ1 = 3'd0, typ2 = 3'd1, typ3 = 3'd2;
  logic [4:0] rng1 = 5'd0, rng2 = 5'd0, rng3 = 5'd0;
  logic       refl = 1'b0;

  letter_scrambler #(.SETTLE_CYCLES(3)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .rotate        (rotate),
    .rotor1        (pos1),
    .rotor2        (pos2),
    .rotor3        (pos3),
    .rotor_type_1  (typ1),
    .rotor_type_2  (typ2),
    .rotor_type_3  (typ3),
    .ring_1        (rng1),
    .ring_2        (rng2),
    .ring_3        (rng3),
    .reflector_sel (refl),
    .bad_letter    (bad_letter),
    .state         (state)
  );

  int checks   = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  // ---------------- reference model ----------------
  string fwd_w [8] = '{
    "EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
    "BDFHJLCPRTXVZNYEIWGAKMUSQO", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
    "VZBRGITYUPSDNHLXAWMJQOFECK", "JPGVOUMFYQBENHZRDKASXLICTW",
    "NZJHGRCXMYSWBOUFAIVLPEKQDT", "FKQHTLXOCBJSPDZRAMEWNIUYGV"
  };
  string ukw [2] = '{"YRUHQSLDPXNGOKMIEBFZCWVJAT", "FVPJIAOYEDRZXWGCTKUQSBNMHL"};
  int mp1, mp2, mp3;

  function automatic int m26(int v);
    return ((v % 26) + 26) % 26;
  endfunction

  function automatic int wire_at(string w, int i);
    return int'(w.getc(i)) - 65;
  endfunction

  function automatic bit at_notch(int t, int p);
    case (t)
      0: return p == 16;
      1: return p == 4;
      2: return p == 21;
      3: return p == 9;
      4: return p == 25;
      default: return (p == 25) || (p == 12);
    endcase
  endfunction

  function automatic int rotor_pass(int x, int t, int p, int r, bit back);
    int sh;
    int i;
    int c;
    sh = m26(p - r);
    i  = m26(x + sh);
    c  = 0;
    if (!back) c = wire_at(fwd_w[t], i);
    else for (int j = 0; j < 26; j++) if (wire_at(fwd_w[t], j) == i) c = j;
    return m26(c - sh);
  endfunction

  function automatic int encrypt(int x);
    int y;
    y = rotor_pass(x, int'(typ3), mp3, int'(rng3), 1'b0);
    y = rotor_pass(y, int'(typ2), mp2, int'(rng2), 1'b0);
    y = rotor_pass(y, int'(typ1), mp1, int'(rng1), 1'b0);
    y = wire_at(ukw[refl], y);
    y = rotor_pass(y, int'(typ1), mp1, int'(rng1), 1'b1);
    y = rotor_pass(y, int'(typ2), mp2, int'(rng2), 1'b1);
    y = rotor_pass(y, int'(typ3), mp3, int'(rng3), 1'b1);
    return y;
  endfunction

  task automatic model_step();
    bit mid_n;
    bit right_n;
    mid_n   = at_notch(int'(typ2), mp2);
    right_n = at_notch(int'(typ3), mp3);
    if (mid_n) mp1 = (mp1 + 1) % 26;
    if (mid_n || right_n) mp2 = (mp2 + 1) % 26;
    mp3 = (mp3 + 1) % 26;
  endtask

  // ---------------- rotor stepping stage ----------------
  logic       load_en = 1'b0;
  logic [4:0] ld1 = 5'd0, ld2 = 5'd0, ld3 = 5'd0;
  logic [4:0] pend1 = 5'd0, pend2 = 5'd0;
  int         stage = 0;
  int         rot_count = 0;

  // Right rotor moves on the rotate edge, middle one edge later, left after that.
  always @(posedge clock) begin
    if (load_en) begin
      pos1 <= ld1; pos2 <= ld2; pos3 <= ld3; stage <= 0;
    end else if (rotate) begin
      rot_count <= rot_count + 1;
      pos3  <= 5'((int'(pos3) + 1) % 26);
      pend2 <= (at_notch(int'(typ2), int'(pos2)) || at_notch(int'(typ3), int'(pos3)))
               ? 5'((int'(pos2) + 1) % 26) : pos2;
      pend1 <= at_notch(int'(typ2), int'(pos2)) ? 5'((int'(pos1) + 1) % 26) : pos1;
      stage <= 1;
    end else if (stage == 1) begin
      pos2 <= pend2; stage <= 2;
    end else if (stage == 2) begin
      pos1 <= pend1; stage <= 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_positions(input int a, input int b, input int c);
    @(negedge clock);
    load_en = 1'b1; ld1 = 5'(a); ld2 = 5'(b); ld3 = 5'(c);
    @(negedge clock);
    load_en = 1'b0;
    mp1 = a; mp2 = b; mp3 = c;
  endtask

  // Offer one key letter and wait (bounded) for out_valid; leaves out_ready low.
  task automatic send_letter(input int plain, output int cipher, output int latency, output bit ok);
    int n;
    ok = 1'b0; cipher = -1; latency = -1; n = 0;
    @(negedge clock);
    bus.in_valid = 1'b1; bus.in_letter = 5'(plain);
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    while (n < 40) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (bus.out_valid) break;
    end
    if (bus.out_valid) begin
      ok = 1'b1; cipher = int'(bus.out_letter); latency = n;
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (rotate !== 1'b0) begin failures++; $display("FAIL reset_rotate got=%b exp=0", rotate); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_letter !== 5'd0) begin failures++; $display("FAIL reset_out_letter got=%0d exp=0", bus.out_letter); end
    checks++; if (bad_letter !== 1'b0) begin failures++; $display("FAIL reset_bad_letter got=%b exp=0", bad_letter); end
    checks++; if (state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state, ST_IDLE); end
    reset = 1'b1;
  endtask

  int known_cipher [5];

  task automatic test_known_vector();
    int exp_const [5] = '{1, 3, 25, 6, 14};
    int c, lat, e;
    bit ok;
    typ1 = 3'd0; typ2 = 3'd1; typ3 = 3'd2;
    rng1 = 5'd0; rng2 = 5'd0; rng3 = 5'd0; refl = 1'b0;
    load_positions(0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      model_step();
      e = encrypt(0);
      send_letter(0, c, lat, ok);
      known_cipher[k] = c;
      checks++; if (!ok) begin failures++; $display("FAIL known_timeout letter=%0d got=no_out_valid exp=out_valid", k); end
      checks++; if (lat != 11) begin failures++; $display("FAIL known_latency letter=%0d got=%0d exp=11", k, lat); end
      checks++; if (c != exp_const[k]) begin failures++; $display("FAIL known_vector letter=%0d got=%0d exp=%0d", k, c, exp_const[k]); end
      checks++; if (c != e) begin failures++; $display("FAIL known_model letter=%0d got=%0d exp=%0d", k, c, e); end
      drain();
    end
    checks++;
    if (pos1 !== 5'd0 || pos2 !== 5'd0 || pos3 !== 5'd5) begin
      failures++; $display("FAIL known_final_pos got=%0d,%0d,%0d exp=0,0,5", pos1, pos2, pos3);
    end
  endtask

  task automatic test_double_step();
    int exp_pos [3][3] = '{'{0, 3, 21}, '{0, 4, 22}, '{1, 5, 23}};
    int p, c, lat, e;
    bit ok;
    load_positions(0, 3, 20);
    for (int k = 0; k < 3; k++) begin
      p = int'($urandom_range(25));
      model_step();
      e = encrypt(p);
      send_letter(p, c, lat, ok);
      checks++;
      if (int'(pos1) != exp_pos[k][0] || int'(pos2) != exp_pos[k][1] || int'(pos3) != exp_pos[k][2]) begin
        failures++;
        $display("FAIL double_step_pos letter=%0d got=%0d,%0d,%0d exp=%0d,%0d,%0d", k, pos1, pos2, pos3,
                 exp_pos[k][0], exp_pos[k][1], exp_pos[k][2]);
      end
      checks++; if (!ok || c != e) begin failures++; $display("FAIL double_step_cipher letter=%0d got=%0d exp=%0d", k, c, e); end
      drain();
    end
  endtask

  task automatic test_backpressure();
    int p, c, lat, e, rc;
    bit ok;
    p = int'($urandom_range(25));
    rc = rot_count;
    model_step();
    e = encrypt(p);
    send_letter(p, c, lat, ok);
    checks++; if (!ok || c != e) begin failures++; $display("FAIL hold_first got=%0d exp=%0d", c, e); end
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b1 || int'(bus.out_letter) != e || bus.in_ready !== 1'b0 || rot_count != rc + 1) begin
        failures++;
        $display("FAIL hold_cycle k=%0d got=valid%b,letter%0d,ready%b,rot%0d exp=valid1,letter%0d,ready0,rot%0d",
                 k, bus.out_valid, bus.out_letter, bus.in_ready, rot_count, e, rc + 1);
      end
    end
    drain();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got=valid%b,ready%b exp=valid0,ready1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_bad_letter();
    int rc, pulses, valids;
    rc = rot_count; pulses = 0; valids = 0;
    @(negedge clock);
    bus.in_valid = 1'b1; bus.in_letter = 5'd28;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    checks++; if (bad_letter !== 1'b1) begin failures++; $display("FAIL bad_pulse got=%b exp=1", bad_letter); end
    for (int k = 0; k < 15; k++) begin
      if (bad_letter === 1'b1) pulses++;
      if (bus.out_valid === 1'b1 || rotate === 1'b1) valids++;
      @(negedge clock);
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL bad_pulse_count got=%0d exp=1", pulses); end
    checks++; if (valids != 0 || rot_count != rc) begin failures++; $display("FAIL bad_no_activity got=%0d,%0d exp=0,%0d", valids, rot_count, rc); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bad_idle got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_hop();
    int p, c, lat, e;
    bit ok;
    @(negedge clock);
    bus.in_valid = 1'b1; bus.in_letter = 5'd7;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    model_step();
    repeat (7) @(posedge clock);
    @(negedge clock);
    checks++; if (state !== ST_HOP) begin failures++; $display("FAIL midhop_state got=%0d exp=%0d", state, ST_HOP); end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1 || rotate !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_letter !== 5'd0 ||
        bad_letter !== 1'b0 || state !== ST_IDLE) begin
      failures++;
      $display("FAIL midhop_reset got=rdy%b,rot%b,vld%b,let%0d,bad%b,st%0d exp=rdy1,rot0,vld0,let0,bad0,st0",
               bus.in_ready, rotate, bus.out_valid, bus.out_letter, bad_letter, state);
    end
    reset = 1'b1;
    repeat (4) @(negedge clock);
    p = int'($urandom_range(25));
    model_step();
    e = encrypt(p);
    send_letter(p, c, lat, ok);
    checks++; if (!ok || c != e || lat != 11) begin failures++; $display("FAIL midhop_next got=%0d,lat%0d exp=%0d,lat11", c, lat, e); end
    drain();
  endtask

  task automatic test_involution();
    int c, lat, e;
    bit ok;
    typ1 = 3'd0; typ2 = 3'd1; typ3 = 3'd2;
    rng1 = 5'd0; rng2 = 5'd0; rng3 = 5'd0; refl = 1'b0;
    load_positions(0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      model_step();
      e = encrypt(known_cipher[k]);
      send_letter(known_cipher[k], c, lat, ok);
      checks++; if (!ok || c != 0) begin failures++; $display("FAIL involution letter=%0d got=%0d exp=0", k, c); end
      checks++; if (c != e) begin failures++; $display("FAIL involution_model letter=%0d got=%0d exp=%0d", k, c, e); end
      drain();
    end
  endtask

  task automatic test_random();
    int p, c, lat, e, selfmap;
    bit ok;
    logic [4:0] x;
    for (int cfg = 0; cfg < 6; cfg++) begin
      typ1 = 3'($urandom_range(7)); typ2 = 3'($urandom_range(7)); typ3 = 3'($urandom_range(7));
      rng1 = 5'($urandom_range(31)); rng2 = 5'($urandom_range(31)); rng3 = 5'($urandom_range(31));
      refl = 1'($urandom_range(1));
      load_positions(int'($urandom_range(25)), int'($urandom_range(25)), int'($urandom_range(25)));
      selfmap = 0;
      for (int k = 0; k < 5; k++) begin
        p = int'($urandom_range(25));
        model_step();
        exp_q.push_back(5'(encrypt(p)));
        send_letter(p, c, lat, ok);
        x = exp_q.pop_front();
        checks++; if (!ok || c != int'(x)) begin failures++; $display("FAIL random cfg=%0d k=%0d got=%0d exp=%0d", cfg, k, c, x); end
        if (c == p) selfmap++;
        drain();
      end
      checks++; if (selfmap != 0) begin failures++; $display("FAIL random_selfmap cfg=%0d got=%0d exp=0", cfg, selfmap); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.in_valid = 1'b0; bus.in_letter = 5'd0; bus.out_ready = 1'b0;
    mp1 = 0; mp2 = 0; mp3 = 0;
    test_reset();
    test_known_vector();
    test_double_step();
    test_backpressure();
    test_bad_letter();
    test_reset_mid_hop();
    test_involution();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/letter_scrambler.md
Name: letter_scrambler

Overview:
- Downstream of the rotor stepping stage: consumes rotor positions rotor1/rotor2/rotor3 and drives that stage's rotate input.
- Per accepted key letter (0..25 = A..Z):
  - pulses rotate;
  - waits for the stepping cascade, including double-step, to settle;
  - routes the letter one hop per cycle: right, middle and left rotor forward, reflector, left, middle and right rotor backward;
  - presents the ciphertext letter on a valid/ready output.
- Plugboard is outside this block.

Parameters:
- SETTLE_CYCLES, 3, cycles waited after the rotate pulse before sampling rotor positions; must be at least 3, which covers rotor3, then knock to rotor2, then knock to rotor1.
- NUM_HOPS, 7, routing hops per letter; fixed, not to be overridden.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  key letter present
- in_letter  in  5  key letter 0..25
- in_ready  out  1  block can accept a letter
- rotate  out  1  step request to the rotor stepping stage
- rotor1  in  5  left rotor position
- rotor2  in  5  middle rotor position
- rotor3  in  5  right rotor position
- rotor_type_1  in  3  left rotor wiring, 0..7 = I..VIII
- rotor_type_2  in  3  middle rotor wiring, 0..7 = I..VIII
- rotor_type_3  in  3  right rotor wiring, 0..7 = I..VIII
- ring_1  in  5  left ring setting 0..25
- ring_2  in  5  middle ring setting 0..25
- ring_3  in  5  right ring setting 0..25
- reflector_sel  in  1  0 = UKW-B, 1 = UKW-C
- out_valid  out  1  ciphertext letter present
- out_letter  out  5  ciphertext letter 0..25
- out_ready  in  1  consumer accepts out_letter
- bad_letter  out  1  one-cycle pulse: an in_letter greater than 25 was consumed

Behaviour:
- Reset (reset == 0 at a clock edge):
  - state IDLE; in_ready=1; rotate=0; out_valid=0; out_letter=0; bad_letter=0; hop counter=0.
  - Any letter in flight is discarded.
  - Reset mid-operation behaves identically from any state.
- States: IDLE, STEP, SETTLE, HOP, DONE.
- IDLE:
  - in_ready=1.
  - in_valid & in_letter <= 25: latch the letter, go to STEP.
  - in_valid & in_letter > 25: consume it, pulse bad_letter next cycle, stay IDLE; no rotate, no output.
- STEP: rotate=1 for exactly one cycle; go to SETTLE.
- SETTLE:
  - rotate=0; count SETTLE_CYCLES cycles, then go to HOP with hop=0.
- HOP:
  - One hop per cycle, hop 0..6, result registered into the working letter.
  - Hops 0/1/2: forward through rotor3 / rotor2 / rotor1.
  - Hop 3: reflector.
  - Hops 4/5/6: inverse through rotor1 / rotor2 / rotor3.
  - After hop 6: load out_letter, go to DONE.
  - Rotor positions are sampled live during HOP; the stepping stage is stable there.
- DONE:
  - out_valid=1, out_letter held stable.
  - out_valid & out_ready: go to IDLE, out_valid=0 next cycle.
  - With default parameters, out_valid rises 11 edges after the accepting edge.
- in_ready is 1 only in IDLE. No overlap between letters: the next accept happens one cycle after the DONE handshake at the earliest.
- Rotor hop arithmetic, with p = position and r = ring:
  - s = (x + p − r) mod 26;
  - w = wiring[s], or inverse wiring for backward hops;
  - y = (w − p + r) mod 26.
- Width rules:
  - Use 6-bit intermediates.
  - Subtraction adds 26 before subtracting; reduce with at most two conditional subtracts of 26.
  - No result may ever exceed 25.
- Out-of-range positions or rings (26..31) are reduced mod 26 before use, never propagated.
- The reflector hop ignores positions and rings.

Decomposition:
- Shared package enigma_pkg holds:
  - LETTERS=26;
  - forward and inverse wiring tables for rotors I..VIII;
  - reflector tables UKW-B and UKW-C;
  - the state encoding;
  - hop index constants.
- One combinational sub-module, rotor_map, instantiated once and shared across hops:
  - inputs: letter, position, ring, rotor type, direction, reflect flag;
  - output: mapped letter.

Test Plan:
- Integrated with the rotor stepping stage. Types I,II,III; rings 0,0,0; UKW-B; start 0,0,0; key A×5 -> out_letter sequence B,D,Z,G,O; final positions 0,0,5.
- Same rotors, start 0,3,20 (A,D,U), three keys -> positions after each letter 0,3,21 / 0,4,22 / 1,5,23. The double-step is captured correctly before HOP.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_letter stable, in_ready=0, no further rotate pulse.
- in_letter=28 with in_valid -> bad_letter pulses once, rotate never rises, out_valid stays 0.
- Drive reset=0 for one cycle during HOP hop=3 -> all outputs at reset values next cycle; next letter processed normally.
- Involution check: feed each ciphertext from the first scenario back at the same start positions -> original plaintext A×5; no letter ever maps to itself.
